// File: rtl/pong_game_ctrl.sv
// Frame-rate pong sequencer: ball/paddle motion, collisions, scoring and the idle/serve/play/over FSM.
// Build macro PONG_AI_R_EN: the right paddle tracks the ball and btn_r is ignored.
module pong_game_ctrl #(
    parameter int unsigned SCR_W        = 640,
    parameter int unsigned SCR_H        = 480,
    parameter int unsigned BALL_SZ      = 8,
    parameter int unsigned PAD_W        = 8,
    parameter int unsigned PAD_H        = 64,
    parameter int unsigned PAD_XL       = 16,
    parameter int unsigned PAD_XR       = 616,
    parameter int unsigned PAD_SPD      = 4,
    parameter int unsigned BALL_SPD     = 2,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        start,
    input  logic [1:0]  btn_l,
    input  logic [1:0]  btn_r,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic [10:0] pad_l_y,
    output logic [10:0] pad_r_y,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic [1:0]  state
);

    localparam int unsigned PW      = 11;
    localparam int unsigned CW      = 12;
    localparam int unsigned SW      = 4;
    localparam int unsigned NW      = 6;
    localparam int unsigned BALL_X0 = (SCR_W - BALL_SZ) / 2;
    localparam int unsigned BALL_Y0 = (SCR_H - BALL_SZ) / 2;
    localparam int unsigned PAD_MAX = SCR_H - PAD_H;
    localparam int unsigned PAD_Y0  = PAD_MAX / 2;

    typedef logic signed [CW-1:0] sval_t;

    localparam sval_t S_SCR_W    = sval_t'(CW'(SCR_W));
    localparam sval_t S_SCR_H    = sval_t'(CW'(SCR_H));
    localparam sval_t S_BALL_SZ  = sval_t'(CW'(BALL_SZ));
    localparam sval_t S_PAD_W    = sval_t'(CW'(PAD_W));
    localparam sval_t S_PAD_H    = sval_t'(CW'(PAD_H));
    localparam sval_t S_PAD_XL   = sval_t'(CW'(PAD_XL));
    localparam sval_t S_PAD_XR   = sval_t'(CW'(PAD_XR));
    localparam sval_t S_BALL_SPD = sval_t'(CW'(BALL_SPD));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    logic          vs_q, vs_qq, tick;
    logic          start_q1, start_q2;
    logic [1:0]    btn_l_q1, btn_l_q2, btn_r_q1, btn_r_q2;

    state_e        state_q, state_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [PW-1:0] pad_l_q, pad_l_d, pad_r_q, pad_r_d;
    logic [SW-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic          dx_q, dx_d, dy_q, dy_d;

    sval_t         bx, by, pl, pr;
    logic          hit_l, hit_r, miss_l, miss_r;

    assign tick = vs_q & ~vs_qq;

    // One paddle step with saturation at the top and bottom of the screen.
    function automatic logic [PW-1:0] pad_step(input logic [PW-1:0] y, input logic up, input logic dn);
        logic [PW-1:0] r;
        r = y;
        if (up && !dn) begin
            r = (y < PW'(PAD_SPD)) ? '0 : y - PW'(PAD_SPD);
        end else if (dn && !up) begin
            r = (y > PW'(PAD_MAX - PAD_SPD)) ? PW'(PAD_MAX) : y + PW'(PAD_SPD);
        end
        return r;
    endfunction

    always_comb begin
        bx     = sval_t'({1'b0, ball_x_q});
        by     = sval_t'({1'b0, ball_y_q});
        pl     = sval_t'({1'b0, pad_l_q});
        pr     = sval_t'({1'b0, pad_r_q});
        hit_l  = !dx_q && (bx >= S_PAD_XL) && (bx <= S_PAD_XL + S_PAD_W)
                 && (by + S_BALL_SZ > pl) && (by < pl + S_PAD_H);
        hit_r  = dx_q && (bx + S_BALL_SZ >= S_PAD_XR) && (bx + S_BALL_SZ <= S_PAD_XR + S_PAD_W)
                 && (by + S_BALL_SZ > pr) && (by < pr + S_PAD_H);
        miss_l = !dx_q && (bx < S_BALL_SPD);
        miss_r = dx_q && (bx + S_BALL_SZ + S_BALL_SPD > S_SCR_W);
    end

`ifdef PONG_AI_R_EN
    localparam sval_t S_PAD_HALF  = sval_t'(CW'(PAD_H / 2));
    localparam sval_t S_BALL_HALF = sval_t'(CW'(BALL_SZ / 2));
    logic ai_up, ai_dn, unused_btn_r;
    assign ai_up        = (pr + S_PAD_HALF) > (by + S_BALL_HALF);
    assign ai_dn        = (pr + S_PAD_HALF) < (by + S_BALL_HALF);
    assign unused_btn_r = ^btn_r_q2;
`endif

    // Next-state: everything holds except in the frame-tick cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        pad_l_d   = pad_l_q;
        pad_r_d   = pad_r_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        if (tick) begin
            if (state_q != ST_IDLE) begin
                pad_l_d = pad_step(pad_l_q, btn_l_q2[1], btn_l_q2[0]);
`ifdef PONG_AI_R_EN
                pad_r_d = pad_step(pad_r_q, ai_up, ai_dn);
`else
                pad_r_d = pad_step(pad_r_q, btn_r_q2[1], btn_r_q2[0]);
`endif
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_q2) begin
                        state_d = ST_SERVE;
                        cnt_d   = '0;
                    end
                end
                ST_SERVE: begin
                    cnt_d = cnt_q + NW'(1);
                    if (cnt_q == NW'(SERVE_FRAMES - 1)) state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    if (!dy_q && (by < S_BALL_SPD)) begin
                        ball_y_d = '0;
                        dy_d     = 1'b1;
                    end else if (dy_q && (by + S_BALL_SZ + S_BALL_SPD > S_SCR_H)) begin
                        ball_y_d = PW'(SCR_H - BALL_SZ);
                        dy_d     = 1'b0;
                    end else begin
                        ball_y_d = PW'(dy_q ? by + S_BALL_SPD : by - S_BALL_SPD);
                    end
                    if (hit_l) begin
                        ball_x_d = PW'(PAD_XL + PAD_W);
                        dx_d     = 1'b1;
                    end else if (hit_r) begin
                        ball_x_d = PW'(PAD_XR - BALL_SZ);
                        dx_d     = 1'b0;
                    end else if (miss_l || miss_r) begin
                        // Re-centre and serve toward whoever conceded.
                        ball_x_d = PW'(BALL_X0);
                        ball_y_d = PW'(BALL_Y0);
                        dx_d     = miss_r;
                        dy_d     = ~dy_q;
                        cnt_d    = '0;
                        if (miss_l) begin
                            score_r_d = score_r_q + SW'(1);
                            state_d   = (score_r_d == SW'(WIN_SCORE)) ? ST_OVER : ST_SERVE;
                        end else begin
                            score_l_d = score_l_q + SW'(1);
                            state_d   = (score_l_d == SW'(WIN_SCORE)) ? ST_OVER : ST_SERVE;
                        end
                    end else begin
                        ball_x_d = PW'(dx_q ? bx + S_BALL_SPD : bx - S_BALL_SPD);
                    end
                end
                ST_OVER: begin
                    if (start_q2) begin
                        score_l_d = '0;
                        score_r_d = '0;
                        cnt_d     = '0;
                        state_d   = ST_SERVE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= 1'b0;
            vs_qq     <= 1'b0;
            start_q1  <= 1'b0;
            start_q2  <= 1'b0;
            btn_l_q1  <= '0;
            btn_l_q2  <= '0;
            btn_r_q1  <= '0;
            btn_r_q2  <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ball_x_q  <= PW'(BALL_X0);
            ball_y_q  <= PW'(BALL_Y0);
            pad_l_q   <= PW'(PAD_Y0);
            pad_r_q   <= PW'(PAD_Y0);
            score_l_q <= '0;
            score_r_q <= '0;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
        end else begin
            vs_q      <= vsync;
            vs_qq     <= vs_q;
            start_q1  <= start;
            start_q2  <= start_q1;
            btn_l_q1  <= btn_l;
            btn_l_q2  <= btn_l_q1;
            btn_r_q1  <= btn_r;
            btn_r_q2  <= btn_r_q1;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            pad_l_q   <= pad_l_d;
            pad_r_q   <= pad_r_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
        end
    end

    assign ball_x  = ball_x_q;
    assign ball_y  = ball_y_q;
    assign pad_l_y = pad_l_q;
    assign pad_r_y = pad_r_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;
    assign state   = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomised bench for pong_game_ctrl against a frame-level behavioural model of the game rules.
module tb_pong_game_ctrl;

    localparam int SCR_W = 640, SCR_H = 480, BALL_SZ = 8, PAD_W = 8, PAD_H = 64;
    localparam int PAD_XL = 16, PAD_XR = 616, PAD_SPD = 4, BALL_SPD = 2;
    localparam int SERVE_FRAMES = 60, WIN_SCORE = 9;
    localparam int BX0 = (SCR_W - BALL_SZ) / 2, BY0 = (SCR_H - BALL_SZ) / 2;
    localparam int PAD_MAX = SCR_H - PAD_H, PY0 = PAD_MAX / 2;

    logic        clk = 1'b0;
    logic        rst_n, vsync, start;
    logic [1:0]  btn_l, btn_r;
    logic [10:0] ball_x, ball_y, pad_l_y, pad_r_y;
    logic [3:0]  score_l, score_r;
    logic [1:0]  state;

    pong_game_ctrl dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .start(start),
        .btn_l(btn_l), .btn_r(btn_r),
        .ball_x(ball_x), .ball_y(ball_y), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
        .score_l(score_l), .score_r(score_r), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int overs  = 0;

    // Game model: state 0..3, positions in pixels, directions as +1/-1.
    int m_state, m_cnt, m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_dx, m_dy;

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string ph);
        check_eq({ph, "_state"}, 32'(state), m_state);
        check_eq({ph, "_ball_x"}, 32'(ball_x), m_bx);
        check_eq({ph, "_ball_y"}, 32'(ball_y), m_by);
        check_eq({ph, "_pad_l"}, 32'(pad_l_y), m_pl);
        check_eq({ph, "_pad_r"}, 32'(pad_r_y), m_pr);
        check_eq({ph, "_score_l"}, 32'(score_l), m_sl);
        check_eq({ph, "_score_r"}, 32'(score_r), m_sr);
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_bx = BX0; m_by = BY0;
        m_pl = PY0; m_pr = PY0; m_sl = 0; m_sr = 0; m_dx = 1; m_dy = 1;
    endtask

    function automatic int pad_move(input int y, input bit up, input bit dn);
        if (up && !dn) return (y - PAD_SPD < 0) ? 0 : y - PAD_SPD;
        if (dn && !up) return (y + PAD_SPD > PAD_MAX) ? PAD_MAX : y + PAD_SPD;
        return y;
    endfunction

    task automatic score_point(input bit left_scores);
        if (left_scores) m_sl++; else m_sr++;
        m_dx    = left_scores ? 1 : -1;
        m_dy    = -m_dy;
        m_bx    = BX0;
        m_by    = BY0;
        m_cnt   = 0;
        m_state = ((left_scores ? m_sl : m_sr) == WIN_SCORE) ? 3 : 1;
        if (m_state == 3) overs++;
    endtask

    task automatic model_tick(input bit st, input bit [1:0] bl, input bit [1:0] br);
        int npl, npr, nbx, nby, ndx, ndy;
        bit ov_l, ov_r;
        npl = m_pl;
        npr = m_pr;
        if (m_state != 0) begin
            npl = pad_move(m_pl, bl[1], bl[0]);
`ifdef PONG_AI_R_EN
            npr = pad_move(m_pr, (m_pr + PAD_H / 2) > (m_by + BALL_SZ / 2),
                                 (m_pr + PAD_H / 2) < (m_by + BALL_SZ / 2));
`else
            npr = pad_move(m_pr, br[1], br[0]);
`endif
        end
        case (m_state)
            0: if (st) begin m_state = 1; m_cnt = 0; end
            1: if (m_cnt == SERVE_FRAMES - 1) m_state = 2; else m_cnt++;
            2: begin
                ndy = m_dy;
                nby = m_by + m_dy * BALL_SPD;
                if (m_dy < 0 && m_by < BALL_SPD) begin nby = 0; ndy = 1; end
                else if (m_dy > 0 && m_by + BALL_SZ + BALL_SPD > SCR_H) begin nby = SCR_H - BALL_SZ; ndy = -1; end
                ov_l = (m_by + BALL_SZ > m_pl) && (m_by < m_pl + PAD_H);
                ov_r = (m_by + BALL_SZ > m_pr) && (m_by < m_pr + PAD_H);
                if (m_dx < 0 && m_bx >= PAD_XL && m_bx <= PAD_XL + PAD_W && ov_l) begin
                    m_bx = PAD_XL + PAD_W; m_dx = 1; m_by = nby; m_dy = ndy;
                end else if (m_dx > 0 && m_bx + BALL_SZ >= PAD_XR && m_bx + BALL_SZ <= PAD_XR + PAD_W && ov_r) begin
                    m_bx = PAD_XR - BALL_SZ; m_dx = -1; m_by = nby; m_dy = ndy;
                end else if (m_dx < 0 && m_bx < BALL_SPD) begin
                    score_point(1'b0);
                end else if (m_dx > 0 && m_bx + BALL_SZ + BALL_SPD > SCR_W) begin
                    score_point(1'b1);
                end else begin
                    nbx = m_bx + m_dx * BALL_SPD;
                    ndx = m_dx;
                    m_bx = nbx; m_dx = ndx; m_by = nby; m_dy = ndy;
                end
            end
            default: if (st) begin m_sl = 0; m_sr = 0; m_cnt = 0; m_state = 1; end
        endcase
        m_pl = npl;
        m_pr = npr;
    endtask

    // One frame: settle inputs through the synchronisers, pulse vsync, check before and after the update.
    task automatic run_frame(input bit st, input bit [1:0] bl, input bit [1:0] br);
        @(negedge clk);
        start = st; btn_l = bl; btn_r = br;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        @(posedge clk); #1;
        check_eq("hold_state", 32'(state), m_state);
        check_eq("hold_ball_x", 32'(ball_x), m_bx);
        model_tick(st, bl, br);
        @(posedge clk); #1;
        check_all("tick");
        @(negedge clk);
        vsync = 1'b0;
    endtask

    function automatic bit [1:0] track(input int pad, input int by);
        if (pad + PAD_H / 2 > by + BALL_SZ / 2) return 2'b10;
        if (pad + PAD_H / 2 < by + BALL_SZ / 2) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit [1:0] pick(input int pad, input int pct_track);
        if (int'($urandom_range(0, 99)) < pct_track) return track(pad, m_by);
        return 2'($urandom_range(0, 3));
    endfunction

    initial begin
        bit st;
        bit [1:0] bl, br;
        int guard;
        rst_n = 1'b0; vsync = 1'b0; start = 1'b0; btn_l = '0; btn_r = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk) rst_n = 1'b1;

        // Idle must ignore paddles and hold the ball until start.
        for (int i = 0; i < 3; i++) run_frame(1'b0, 2'b01, 2'b10);
        run_frame(1'b1, 2'b00, 2'b00);
        for (int i = 0; i < 5; i++) run_frame(1'b1, 2'b10, 2'b01);

        guard = 0;
        while (m_state != 2 && guard < 200) begin
            run_frame(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            guard++;
        end
        check_eq("reach_play", 32'(m_state), 2);
        for (int i = 0; i < 7; i++) run_frame(1'b0, 2'b01, 2'b10);

        // Asynchronous reset in the middle of play.
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk) rst_n = 1'b1;
        run_frame(1'b0, 2'b01, 2'b01);
        run_frame(1'b1, 2'b00, 2'b00);

        // Rallies: both paddles mostly follow the ball.
        for (int i = 0; i < 1500; i++) begin
            st = ($urandom_range(0, 39) == 0);
            bl = pick(m_pl, 75);
            br = pick(m_pr, 75);
            run_frame(st, bl, br);
        end

        // Left paddle runs away from the ball so points accumulate toward game over.
        for (int i = 0; i < 2500; i++) begin
            st = ($urandom_range(0, 39) == 0);
            bl = ~track(m_pl, m_by);
            if (bl == 2'b11) bl = 2'b00;
            br = pick(m_pr, 50);
            run_frame(st, bl, br);
        end

        $display("games ended: %0d", overs);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
